// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame path: state encoding and frame
// length helpers, used by serial_tx and the future serial_rx.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // Counter width for a modulus n, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clocks from the accept edge to the edge that returns to IDLE.
    function automatic int frame_clks(input int data_w, input int cpb, input int par_en);
        return (data_w + 2 + par_en) * cpb;
    endfunction

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses wrap_o on the last
// count. With CLKS_PER_BIT==1 the count stays 0 and wrap_o is always high.
module baud_tick
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int CW = cnt_w(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || wrap_o)
            cnt_d = '0;
    end

    // Falling-edge update, matching the receive-stage flops.
    always_ff @(negedge clk_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start(0), data LSB-first, optional
// even parity, stop(1), each bit held CLKS_PER_BIT clocks. Falling-edge state.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    output logic              ntxd,
    output logic              busy
);

    localparam int IDX_W = cnt_w(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              par_q, par_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              wrap;

    // Counter is held at 0 while idle so the accept edge starts a fresh bit.
    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clr_i   (state_q == S_IDLE),
        .wrap_o  (wrap)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_START;
                    shreg_d = tx_data;
                    par_d   = ^tx_data;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (wrap)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (wrap) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (wrap)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (wrap)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Line level is a function of the next state so txd stays registered.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign txd      = txd_q;
    assign ntxd     = ~txd_q;
    assign busy     = busy_q;

endmodule
